spi_slave: RTL and testbench

//  SPI target (slave) endpoint: the far end of the ahb_spi master link. Oversamples the
//  SPI pins in the hclk domain, receives 8-bit MSB-first frames on spi_mosi_i and returns
//  a byte on spi_miso_o in the same frame. Supports modes 0-3 via cpol_i/cpha_i.

---
 rtl/spi_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave -- SPI target endpoint, oversampled in the hclk domain.
//
// Receives 8-bit MSB-first frames on spi_mosi_i and returns a byte on spi_miso_o in
// the same frame. SPI modes 0-3 are selected with cpol_i/cpha_i. The SPI pins are
// synchronised into hclk, and edges are found by comparing the last sync stage with
// one extra flop, so every SCK/NSS event is seen SYNC_STAGES+1 hclk after the pin moves.
// SCK half-period must be at least SYNC_STAGES+2 hclk.
//
// Ports
//   hclk, hreset            system clock, synchronous active-high reset
//   cpol_i, cpha_i          SPI mode (static while a frame is in progress)
//   spi_clk_i/nss_i/mosi_i  asynchronous SPI pins from the master
//   spi_miso_o, _oe_o       slave-out data and its drive enable
//   tx_data_i/valid_i/ready_o  byte to return (single holding register)
//   rx_data_o/valid_o/ready_i  received byte (held until accepted)
//   overrun_o, underrun_o   one-cycle error pulses
//   busy_o                  synchronised NSS is low
module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       spi_clk_i,
  input  logic       spi_nss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       overrun_o,
  output logic       underrun_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   nss_prev_q, nss_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             tx_hold_q, tx_hold_d;
  logic                   tx_full_q, tx_full_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;
  logic                   underrun_pend_q, underrun_pend_d;

  logic sck_s, nss_s, mosi_s;
  logic sck_edge_s, lead_s, trail_s, nss_fall_s;
  logic in_shift_s, sample_s, shift_s, first_lead_s;
  logic [7:0] rx_byte_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign nss_s  = nss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sck_edge_s = sck_s ^ sck_prev_q;
  assign lead_s     = sck_edge_s & (sck_prev_q == cpol_i);
  assign trail_s    = sck_edge_s & (sck_s == cpol_i);
  assign nss_fall_s = nss_prev_q & ~nss_s;

  // The edge at bit count 0 never shifts TX: for cpha=0 it is the trailing edge after
  // the last sample (the next byte is already loaded), for cpha=1 it is the first
  // leading edge, which only presents the MSB.
  assign in_shift_s   = (state_q == ST_SHIFT);
  assign sample_s     = in_shift_s & (cpha_i ? trail_s : lead_s);
  assign shift_s      = in_shift_s & (cpha_i ? lead_s : trail_s) & (bit_cnt_q != 3'd0);
  assign first_lead_s = in_shift_s & lead_s & (bit_cnt_q == 3'd0);
  assign rx_byte_s    = {rx_shift_q[6:0], mosi_s};

  assign spi_miso_o    = tx_shift_q[7];
  assign spi_miso_oe_o = ~nss_s;
  assign busy_o        = ~nss_s;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign overrun_o     = overrun_q;
  assign underrun_o    = underrun_q;

  // Next-state logic: synchronisers, FSM, shift registers and handshakes.
  always_comb begin
    sck_sync_d      = {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    nss_sync_d      = {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
    mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sck_prev_d      = sck_s;
    nss_prev_d      = nss_s;
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    tx_shift_d      = tx_shift_q;
    tx_hold_d       = tx_hold_q;
    tx_full_d       = tx_full_q;
    rx_shift_d      = rx_shift_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    overrun_d       = 1'b0;
    underrun_d      = 1'b0;
    underrun_pend_d = underrun_pend_q;

    // Consumer handshake first so a completing byte in the same cycle replaces it.
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        if (nss_fall_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
        if (tx_full_q) begin
          tx_shift_d      = tx_hold_q;
          tx_full_d       = 1'b0;
          underrun_pend_d = 1'b0;
        end else begin
          // Underrun is reported when the byte actually starts, so a frame that ends
          // right after its last byte does not flag a spurious underrun.
          tx_shift_d      = IDLE_BYTE;
          underrun_pend_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (first_lead_s && underrun_pend_q) begin
          underrun_d      = 1'b1;
          underrun_pend_d = 1'b0;
        end else begin
          underrun_d      = 1'b0;
        end
        if (shift_s) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else begin
          tx_shift_d = tx_shift_q;
        end
        if (sample_s) begin
          rx_shift_d = rx_byte_s;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_LOAD;
            if (rx_valid_q && !rx_ready_i) begin
              overrun_d = 1'b1;
            end else begin
              rx_data_d  = rx_byte_s;
              rx_valid_d = 1'b1;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase

    // NSS high aborts any frame: partial RX and the loaded TX byte are discarded.
    if (nss_s) begin
      state_d         = ST_IDLE;
      bit_cnt_d       = 3'd0;
      underrun_pend_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    // LOAD only consumes a full register, so it never coincides with a write.
    if (tx_valid_i && !tx_full_q) begin
      tx_hold_d = tx_data_i;
      tx_full_d = 1'b1;
    end else begin
      tx_hold_d = tx_hold_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q         <= ST_IDLE;
      sck_sync_q      <= '0;
      nss_sync_q      <= '1;
      mosi_sync_q     <= '0;
      sck_prev_q      <= 1'b0;
      nss_prev_q      <= 1'b1;
      bit_cnt_q       <= 3'd0;
      tx_shift_q      <= 8'h00;
      tx_hold_q       <= 8'h00;
      tx_full_q       <= 1'b0;
      rx_shift_q      <= 8'h00;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      overrun_q       <= 1'b0;
      underrun_q      <= 1'b0;
      underrun_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sck_sync_q      <= sck_sync_d;
      nss_sync_q      <= nss_sync_d;
      mosi_sync_q     <= mosi_sync_d;
      sck_prev_q      <= sck_prev_d;
      nss_prev_q      <= nss_prev_d;
      bit_cnt_q       <= bit_cnt_d;
      tx_shift_q      <= tx_shift_d;
      tx_hold_q       <= tx_hold_d;
      tx_full_q       <= tx_full_d;
      rx_shift_q      <= rx_shift_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      overrun_q       <= overrun_d;
      underrun_q      <= underrun_d;
      underrun_pend_q <= underrun_pend_d;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed bench for spi_slave with an RX scoreboard.
// A master model drives SCK/NSS/MOSI; expected RX bytes are queued when a frame is
// issued and popped by a monitor on every rx_valid_o/rx_ready_i handshake.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       cpol, cpha;
  logic       sck, nss, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       overrun, underrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_unr    = 0;
  logic [7:0] exp_rx_q[$];

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .hclk(hclk), .hreset(hreset), .cpol_i(cpol), .cpha_i(cpha),
    .spi_clk_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .overrun_o(overrun), .underrun_o(underrun), .busy_o(busy)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // RX scoreboard monitor and error-pulse counters.
  always @(negedge hclk) begin
    if (!hreset) begin
      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
        end else begin
          chk("rx_byte", rx_data, exp_rx_q.pop_front());
        end
      end
      if (overrun)  n_ovr++;
      if (underrun) n_unr++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic half_period();
    repeat (HALF) @(posedge hclk);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sck  = p;
    repeat (10) @(posedge hclk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    int cnt;
    cnt = 0;
    @(posedge hclk);
    #1;
    while (!tx_ready && cnt < 2000) begin
      @(posedge hclk);
      #1;
      cnt++;
    end
    chk("tx_ready_wait", tx_ready, 1'b1);
    if (tx_ready) begin
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge hclk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic nss_low();
    nss = 1'b0;
    repeat (8) @(posedge hclk);
    #1;
  endtask

  task automatic nss_high();
    half_period();
    nss = 1'b1;
    repeat (10) @(posedge hclk);
    #1;
  endtask

  // Master side of one byte (or fewer bits); returns what was seen on MISO.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    if (!cpha) begin
      mosi = mo[7];
      for (int i = 0; i < nbits; i++) begin
        half_period();
        sck = ~cpol;
        mi  = {mi[6:0], miso};
        half_period();
        sck = cpol;
        if (i < 7) mosi = mo[6-i];
      end
    end else begin
      for (int i = 0; i < nbits; i++) begin
        half_period();
        sck  = ~cpol;
        mosi = mo[7-i];
        half_period();
        sck  = cpol;
        mi   = {mi[6:0], miso};
      end
    end
  endtask

  task automatic single_frame(input logic [7:0] mo, output logic [7:0] mi);
    nss_low();
    spi_byte(mo, 8, mi);
    nss_high();
  endtask

  logic [7:0] got, g1, g2, g3;
  int unr0, ovr0;

  initial begin
    hreset = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sck = 1'b0; nss = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {overrun, underrun}, 2'b00);

    // Mode 0 basic exchange.
    set_mode(1'b0, 1'b0);
    tx_push(8'hA5);
    unr0 = n_unr;
    exp_rx_q.push_back(8'h3C);
    single_frame(8'h3C, got);
    chk("m0_miso", got, 8'hA5);
    chk("m0_underrun", n_unr - unr0, 0);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_push(8'hC3);
      exp_rx_q.push_back(8'h5A);
      single_frame(8'h5A, got);
      chk($sformatf("m%0d_miso", m), got, 8'hC3);
    end

    // 3-byte burst with refill.
    set_mode(1'b0, 1'b0);
    tx_push(8'h10);
    unr0 = n_unr;
    exp_rx_q.push_back(8'h81);
    exp_rx_q.push_back(8'h42);
    exp_rx_q.push_back(8'h24);
    fork
      begin
        nss_low();
        spi_byte(8'h81, 8, g1);
        spi_byte(8'h42, 8, g2);
        spi_byte(8'h24, 8, g3);
        nss_high();
      end
      begin
        tx_push(8'h20);
        tx_push(8'h30);
      end
    join
    chk("burst_b1", g1, 8'h10);
    chk("burst_b2", g2, 8'h20);
    chk("burst_b3", g3, 8'h30);
    chk("burst_underrun", n_unr - unr0, 0);

    // Underrun on second byte (mode 3).
    set_mode(1'b1, 1'b1);
    tx_push(8'h55);
    unr0 = n_unr;
    exp_rx_q.push_back(8'h01);
    exp_rx_q.push_back(8'h02);
    nss_low();
    spi_byte(8'h01, 8, g1);
    spi_byte(8'h02, 8, g2);
    nss_high();
    chk("unr_b1", g1, 8'h55);
    chk("unr_b2", g2, 8'hFF);
    chk("unr_pulses", n_unr - unr0, 1);

    // Overrun: consumer stalled across two bytes.
    set_mode(1'b0, 1'b0);
    rx_ready = 1'b0;
    ovr0 = n_ovr;
    exp_rx_q.push_back(8'h11);
    single_frame(8'h11, got);
    single_frame(8'h22, got);
    @(negedge hclk);
    chk("ovr_rx_data", rx_data, 8'h11);
    chk("ovr_rx_valid", rx_valid, 1'b1);
    chk("ovr_pulses", n_ovr - ovr0, 1);
    rx_ready = 1'b1;
    repeat (4) @(posedge hclk);
    #1;
    chk("ovr_drained", exp_rx_q.size(), 0);

    // NSS raised after 5 bits, then a full frame.
    nss_low();
    spi_byte(8'hE7, 5, got);
    nss_high();
    @(negedge hclk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rx_valid", rx_valid, 1'b0);
    tx_push(8'h81);
    exp_rx_q.push_back(8'h7E);
    single_frame(8'h7E, got);
    chk("abort_next_miso", got, 8'h81);

    // Reset in the middle of a frame.
    tx_push(8'h99);
    nss_low();
    spi_byte(8'hF0, 4, got);
    hreset = 1'b1;
    nss    = 1'b1;
    sck    = cpol;
    @(posedge hclk);
    @(negedge hclk);
    chk("mrst_miso", miso, 1'b0);
    chk("mrst_miso_oe", miso_oe, 1'b0);
    chk("mrst_tx_ready", tx_ready, 1'b1);
    chk("mrst_rx_valid", rx_valid, 1'b0);
    chk("mrst_rx_data", rx_data, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_pulses", {overrun, underrun}, 2'b00);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    repeat (5) @(posedge hclk);
    #1;
    tx_push(8'h3C);
    exp_rx_q.push_back(8'hA5);
    single_frame(8'hA5, got);
    chk("mrst_next_miso", got, 8'h3C);

    repeat (10) @(posedge hclk);
    #1;
    chk("final_rx_queue", exp_rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
